// File: rtl/md_unit_param.sv
// Multiply/divide unit owning the HI/LO pair: MULT/MADD/MSUB and a restoring bit-serial DIV.
// Latency: MUL_CYCLES busy cycles for multiply-class ops, WIDTH for divides; done pulses on commit.
// No backpressure: start is ignored while busy, and flush aborts without touching HI/LO.
module md_unit_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    input  logic             rd_sel,
    input  logic             flush,
    output logic [WIDTH-1:0] rd,
    output logic             busy,
    output logic             done
);
    localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES - 1 : WIDTH - 1;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]    MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0]    DIV_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 commit;
    logic                 accept;
    logic                 is_div_in;
    logic                 sgn_in;

    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2:0]           op_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     rem_q, quo_q;
    logic                 dbz_q, q_neg_q, r_neg_q;

    logic [WIDTH:0]       rem_sh, diff;
    logic                 ge;
    logic [WIDTH-1:0]     rem_nx, quo_nx;
    logic                 msgn;
    logic [2*WIDTH-1:0]   a_ext, b_ext, product, mul_res;
    logic [WIDTH-1:0]     hi_nx, lo_nx;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + ONE) : x;
    endfunction

    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign done      = (state_q == S_DONE);
    assign rd        = rd_sel ? hi_q : lo_q;
    assign accept    = start && !flush && !busy;
    assign is_div_in = (op == 3'd2) || (op == 3'd3);
    assign sgn_in    = ~op[0];

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept)                state_d = is_div_in ? S_DIV : S_MUL;
                else if (state_q == S_DONE) state_d = S_IDLE;
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One restoring step; the borrow out of diff doubles as the compare result.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        ge     = ~diff[WIDTH];
        rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ge};
    end

    always_comb begin
        msgn    = ~op_q[0];
        a_ext   = {{WIDTH{msgn & a_q[WIDTH-1]}}, a_q};
        b_ext   = {{WIDTH{msgn & b_q[WIDTH-1]}}, b_q};
        product = a_ext * b_ext;
        case (op_q)
            3'd4, 3'd5: mul_res = acc_q + product;
            3'd6, 3'd7: mul_res = acc_q - product;
            default:    mul_res = product;
        endcase
    end

    always_comb begin
        hi_nx = mul_res[2*WIDTH-1:WIDTH];
        lo_nx = mul_res[WIDTH-1:0];
        if (state_q == S_DIV) begin
            if (dbz_q) begin
                hi_nx = a_q;
                lo_nx = '1;
            end else begin
                hi_nx = r_neg_q ? (~rem_nx + ONE) : rem_nx;
                lo_nx = q_neg_q ? (~quo_nx + ONE) : quo_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dbz_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op;
                a_q     <= src_a;
                b_q     <= is_div_in ? mag(src_b, sgn_in) : src_b;
                acc_q   <= {hi_q, lo_q};
                quo_q   <= mag(src_a, sgn_in);
                rem_q   <= '0;
                dbz_q   <= (src_b == '0);
                q_neg_q <= sgn_in & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                r_neg_q <= sgn_in & src_a[WIDTH-1];
                cnt_q   <= is_div_in ? DIV_LOAD : MUL_LOAD;
            end else if (busy && !flush) begin
                if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
                if (state_q == S_DIV) begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                end
            end

            // MTHI/MTLO only land while idle and not being overridden by a start.
            if (commit) begin
                hi_q <= hi_nx;
                lo_q <= lo_nx;
            end else if (!busy && !start) begin
                if (hi_we) hi_q <= wd;
                if (lo_we) lo_q <= wd;
            end
        end
    end
endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: two instances (32-bit/5-cycle and 16-bit/1-cycle) against an arithmetic model.
module tb_md_unit_param;
    logic        clk = 1'b0;
    logic [1:0]  reset_v, start_v, hi_we_v, lo_we_v, flush_v, rd_sel_v;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, wd;
    logic [31:0] rd0;
    logic [15:0] rd1;
    logic        busy0, busy1, done0, done1;
    logic [63:0] hi_m [2];
    logic [63:0] lo_m [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    md_unit_param #(.WIDTH(32), .MUL_CYCLES(5)) dut32 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we_v[0]), .lo_we(lo_we_v[0]),
        .wd(wd), .rd_sel(rd_sel_v[0]), .flush(flush_v[0]),
        .rd(rd0), .busy(busy0), .done(done0)
    );

    md_unit_param #(.WIDTH(16), .MUL_CYCLES(1)) dut16 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .op(op),
        .src_a(src_a[15:0]), .src_b(src_b[15:0]), .hi_we(hi_we_v[1]), .lo_we(lo_we_v[1]),
        .wd(wd[15:0]), .rd_sel(rd_sel_v[1]), .flush(flush_v[1]),
        .rd(rd1), .busy(busy1), .done(done1)
    );

    function automatic logic [63:0] mask_of(input int d);
        return d ? 64'hFFFF : 64'hFFFF_FFFF;
    endfunction

    function automatic logic [63:0] rd_of(input int d);
        return d ? {48'd0, rd1} : {32'd0, rd0};
    endfunction

    function automatic logic busy_of(input int d);
        return d ? busy1 : busy0;
    endfunction

    function automatic logic done_of(input int d);
        return d ? done1 : done0;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural values.
    function automatic void model(input int d, input logic [2:0] o,
                                  input logic [31:0] a_in, input logic [31:0] b_in,
                                  input logic [63:0] hi, input logic [63:0] lo,
                                  output logic [63:0] nh, output logic [63:0] nl);
        int          w;
        logic [63:0] m, a, b, acc, res;
        longint      sa, sb, p;
        bit          sg;
        w  = d ? 16 : 32;
        m  = mask_of(d);
        a  = {32'd0, a_in} & m;
        b  = {32'd0, b_in} & m;
        sg = (o == 3'd0) || (o == 3'd2) || (o == 3'd4) || (o == 3'd6);
        sa = (sg && a[w-1]) ? longint'(a | ~m) : longint'(a);
        sb = (sg && b[w-1]) ? longint'(b | ~m) : longint'(b);
        if (o == 3'd2 || o == 3'd3) begin
            if (b == 64'd0) begin
                nl = m;
                nh = a;
            end else if (sg) begin
                nl = 64'(sa / sb) & m;
                nh = 64'(sa % sb) & m;
            end else begin
                nl = (a / b) & m;
                nh = (a % b) & m;
            end
        end else begin
            p   = sa * sb;
            acc = (hi << w) | lo;
            if (o == 3'd4 || o == 3'd5)      res = acc + 64'(p);
            else if (o == 3'd6 || o == 3'd7) res = acc - 64'(p);
            else                             res = 64'(p);
            if (w == 16) res = res & 64'hFFFF_FFFF;
            nh = (res >> w) & m;
            nl = res & m;
        end
    endfunction

    task automatic read_hilo(input int d, output logic [63:0] h, output logic [63:0] l);
        rd_sel_v[d] = 1'b1;
        #1 h = rd_of(d);
        rd_sel_v[d] = 1'b0;
        #1 l = rd_of(d);
    endtask

    task automatic expect_hilo(input int d, input string tag, input logic [63:0] eh, input logic [63:0] el);
        logic [63:0] h, l;
        read_hilo(d, h, l);
        check_eq({tag, "_hi"}, h, eh & mask_of(d));
        check_eq({tag, "_lo"}, l, el & mask_of(d));
    endtask

    task automatic mt_write(input int d, input bit hw, input bit lw, input logic [31:0] data);
        hi_we_v[d] = hw;
        lo_we_v[d] = lw;
        wd = data;
        @(negedge clk);
        hi_we_v[d] = 1'b0;
        lo_we_v[d] = 1'b0;
        if (hw) hi_m[d] = {32'd0, data} & mask_of(d);
        if (lw) lo_m[d] = {32'd0, data} & mask_of(d);
        expect_hilo(d, "mt_write", hi_m[d], lo_m[d]);
    endtask

    // Called at a negedge; drives start there (so a chained call lands in the done cycle).
    task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit chain, input bit poke);
        logic [63:0] eh, el;
        int          n, exp_n;
        model(d, o, a, b, hi_m[d], lo_m[d], eh, el);
        exp_n = (o == 3'd2 || o == 3'd3) ? (d ? 16 : 32) : (d ? 1 : 5);
        op = o; src_a = a; src_b = b;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        n = 0;
        while (busy_of(d) && n < 100) begin
            if (n == 0) check_eq("rd_pre_op", rd_of(d), lo_m[d]);
            if (poke) begin
                lo_we_v[d] = (n == 1);
                wd         = $urandom;
                start_v[d] = (n == 2);
                if (n == 2) op = 3'd2;
            end
            if (n == flush_at) flush_v[d] = 1'b1;
            n++;
            @(negedge clk);
            flush_v[d] = 1'b0;
        end
        start_v[d] = 1'b0;
        lo_we_v[d] = 1'b0;
        if (flush_at >= 0) begin
            check_eq("flush_cycles", 64'(n), 64'(flush_at + 1));
            check_eq("flush_no_done", {63'd0, done_of(d)}, 64'd0);
            expect_hilo(d, "flush_hold", hi_m[d], lo_m[d]);
        end else begin
            check_eq("busy_cycles", 64'(n), 64'(exp_n));
            check_eq("done_on_commit", {63'd0, done_of(d)}, 64'd1);
            expect_hilo(d, "result", eh, el);
            hi_m[d] = eh;
            lo_m[d] = el;
            if (!chain) begin
                @(negedge clk);
                check_eq("done_one_cycle", {63'd0, done_of(d)}, 64'd0);
            end
        end
    endtask

    task automatic reset_mid(input int d);
        bit seen;
        op = d ? 3'd3 : 3'd0;
        src_a = $urandom;
        src_b = $urandom | 32'd1;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        @(negedge clk);
        reset_v[d] = 1'b0;
        @(negedge clk);
        reset_v[d] = 1'b1;
        check_eq("rst_mid_busy", {63'd0, busy_of(d)}, 64'd0);
        expect_hilo(d, "rst_mid", 64'd0, 64'd0);
        hi_m[d] = 64'd0;
        lo_m[d] = 64'd0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_of(d)) seen = 1'b1;
        end
        check_eq("rst_mid_no_done", {63'd0, seen}, 64'd0);
    endtask

    initial begin
        reset_v = 2'b00; start_v = 2'b00; hi_we_v = 2'b00; lo_we_v = 2'b00;
        flush_v = 2'b00; rd_sel_v = 2'b00;
        op = 3'd0; src_a = '0; src_b = '0; wd = '0;
        repeat (3) @(negedge clk);
        reset_v = 2'b11;
        for (int d = 0; d < 2; d++) begin
            hi_m[d] = 64'd0;
            lo_m[d] = 64'd0;
            check_eq("reset_busy", {63'd0, busy_of(d)}, 64'd0);
            check_eq("reset_done", {63'd0, done_of(d)}, 64'd0);
            expect_hilo(d, "reset", 64'd0, 64'd0);
        end

        for (int d = 0; d < 2; d++) begin
            logic [31:0] mn;
            mn = d ? 32'h8000 : 32'h8000_0000;
            run_op(d, 3'd0, 32'hFFFF_FFFD, 32'd5, -1, 0, 0);
            expect_hilo(d, "mult_k", 64'hFFFF_FFFF, 64'hFFFF_FFF1);
            run_op(d, 3'd3, 32'd100, 32'd7, -1, 0, 0);
            expect_hilo(d, "divu_k", 64'd2, 64'd14);
            run_op(d, 3'd2, 32'hFFFF_FFF9, 32'd2, -1, 0, 0);
            expect_hilo(d, "div_neg_k", 64'hFFFF_FFFF, 64'hFFFF_FFFD);
            run_op(d, 3'd2, mn, 32'hFFFF_FFFF, -1, 0, 0);
            expect_hilo(d, "div_min_k", 64'd0, {32'd0, mn});
            run_op(d, 3'd2, 32'd9, 32'd0, -1, 0, 0);
            expect_hilo(d, "div_zero_k", 64'd9, 64'hFFFF_FFFF);
            mt_write(d, 1'b1, 1'b0, 32'd0);
            mt_write(d, 1'b0, 1'b1, 32'd10);
            run_op(d, 3'd5, 32'd3, 32'd4, -1, 0, d == 0);
            expect_hilo(d, "maddu_k", 64'd0, 64'd22);
            run_op(d, 3'd7, 32'd5, 32'd5, -1, 0, 0);
            expect_hilo(d, "msubu_k", 64'hFFFF_FFFF, 64'hFFFF_FFFD);
            run_op(d, 3'd3, 32'd1000, 32'd3, 9, 0, 0);
            reset_mid(d);
            run_op(d, 3'd0, 32'hFFFF_FFFD, 32'd5, -1, 1, 0);
            run_op(d, 3'd3, 32'd100, 32'd7, -1, 0, 0);
            expect_hilo(d, "chain_k", 64'd2, 64'd14);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                int          r, cyc, fa;
                logic [2:0]  o;
                logic [31:0] a, b;
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    mt_write(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                end else begin
                    o = 3'($urandom_range(0, 7));
                    a = $urandom;
                    b = $urandom;
                    if (r == 1) b = 32'd0;
                    if (r == 2) begin
                        a = d ? 32'h8000 : 32'h8000_0000;
                        b = 32'hFFFF_FFFF;
                    end
                    if (r == 3) b = 32'($urandom_range(1, 15));
                    cyc = (o == 3'd2 || o == 3'd3) ? (d ? 16 : 32) : (d ? 1 : 5);
                    fa  = (r == 4) ? int'($urandom_range(0, cyc - 1)) : -1;
                    run_op(d, o, a, b, fa, 0, 0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the EX stage, holding the architectural HI/LO pair. It is the successor to the fixed 32-bit MDM.
- Adds configurable data width and multiply latency, a bit-serial divider, multiply-accumulate ops (MADD/MSUB), a defined divide-by-zero result, a completion pulse, and a flush input for exception cancellation.
- Hazard logic stalls MF/MT/MD instructions in ID while (start | busy).

Parameters:
- WIDTH, 32: operand width and HI/LO width. Legal: 8..64, even.
- MUL_CYCLES, 5: busy cycles for all multiply-class ops. Legal: >=1.
- DIV_CYCLES: fixed at WIDTH (one quotient bit per cycle); not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 clears state at the next clk edge)
- start  in  1  launch the operation in op; sampled only when busy==0
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- src_a  in  WIDTH  rs operand (multiplicand or dividend)
- src_b  in  WIDTH  rt operand (multiplier or divisor)
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wd  in  WIDTH  MTHI/MTLO write data
- rd_sel  in  1  1 selects HI, 0 selects LO for rd
- flush  in  1  abort the in-flight operation
- rd  out  WIDTH  combinational HI or LO (MFHI/MFLO)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse on the cycle HI/LO commit

Behaviour:
- Reset (reset==0 at clk edge): HI=0, LO=0, busy=0, done=0, counter=0, FSM=IDLE. Reset mid-operation discards it with no HI/LO write. Reset overrides every other input.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0:
  - Latch src_a, src_b, op, and HI/LO (accumulate base).
  - Go to MUL (op 0,1,4..7) or DIV (op 2,3). busy=1 from the next cycle.
- MUL: counter runs MUL_CYCLES-1 down to 0. Product = src_a*src_b as 2*WIDTH bits, signed or unsigned per op.
  - MULT/MULTU: {HI,LO} = product.
  - MADD*: {HI,LO} = latched {HI,LO} + product, mod 2^(2*WIDTH).
  - MSUB*: {HI,LO} = latched {HI,LO} - product, mod 2^(2*WIDTH).
- DIV: restoring, one bit per cycle, WIDTH cycles on operand magnitudes; sign fix-up is applied in the final cycle.
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - Signed MIN / -1: LO = MIN, HI = 0.
- Divide by zero (src_b==0 at start): still busy for WIDTH cycles. LO = all ones, HI = src_a.
- Commit: on the edge ending the last busy cycle, HI/LO are written, busy goes 0 and the FSM enters DONE. done=1 for exactly one cycle in DONE, then IDLE.
  - Total busy cycles = MUL_CYCLES or WIDTH.
  - Back-to-back: start is accepted in DONE (busy==0 there).
- flush=1 while busy: the op is aborted at that edge. busy=0 next cycle, HI/LO unchanged, no done pulse.
- flush with start in the same cycle: start is ignored.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - Write HI/LO at the edge when busy==0 and start==0.
  - Ignored when busy==1 or start==1 (start has priority).
  - hi_we and lo_we together write both.
- rd: combinational mux of the current HI/LO registers. During busy it shows the pre-operation values. The committed value is visible in the cycle done==1.
- Operand inputs may change freely after the start edge.

Test Plan:
- Reset then MULT WIDTH=32, src_a=-3 (0xFFFFFFFD), src_b=5, start 1 cycle -> busy=1 for 5 cycles; done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 100/7 -> busy exactly 32 cycles; LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIV 9/0 -> busy 32 cycles; LO=0xFFFFFFFF, HI=9.
- MTHI 0, MTLO 10, then MADDU 3*4 -> LO=22, HI=0. MSUBU 5*5 -> {HI,LO}=0xFFFFFFFF_FFFFFFFD. MTLO asserted during busy -> LO unaffected.
- DIVU started; flush at busy cycle 10 -> busy=0 next cycle, HI/LO hold prior values, no done. reset=0 mid-MULT -> HI=LO=0, busy=0.
- Second start while busy -> ignored. Start asserted in the done cycle -> accepted. Rerun the MULT/DIVU cases with WIDTH=16, MUL_CYCLES=1 -> busy 1 and 16 cycles.
